// File: rtl/wb_req_master_if.sv
// Bundles the command, response and Wishbone request/response signals of wb_req_master.
// master is the block's own view; slave is the view of whatever drives it.
interface wb_req_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_we;
  logic [10:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [3:0]  wb_we_o;
  logic [10:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic [31:0] wb_data_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  wb_stall_i, wb_ack_i, wb_data_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output wb_stall_i, wb_ack_i, wb_data_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/wb_req_master.sv
// Single-outstanding command-to-Wishbone (pipelined) request master with a bus-cycle timeout.
// A timed-out transaction still returns a response, flagged with rsp_err.
module wb_req_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  wb_req_master_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      st_q, st_d;
  logic [3:0]  we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic cmd_fire;
  logic acked;
  logic timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    cmd_fire  = bus.cmd_valid && (st_q == StIdle) && !rst;
    // An ack only counts once the strobe has been (or is being) accepted.
    acked     = bus.wb_ack_i && ((st_q == StWait) || ((st_q == StReq) && !bus.wb_stall_i));
    timed_out = (cnt_q == CntLast);

    unique case (st_q)
      StIdle: begin
        if (cmd_fire) begin
          st_d    = StReq;
          we_d    = bus.cmd_we;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          cnt_d   = '0;
        end
      end
      StReq, StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (acked) begin
          st_d    = StResp;
          rdata_d = (we_q == 4'b0000) ? bus.wb_data_i : '0;
          err_d   = 1'b0;
        end else if (timed_out) begin
          st_d    = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if ((st_q == StReq) && !bus.wb_stall_i) begin
          st_d = StWait;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          st_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    bus.cmd_ready = (st_q == StIdle) && !rst;
    bus.rsp_valid = (st_q == StResp);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.wb_cyc_o  = (st_q == StReq) || (st_q == StWait);
    bus.wb_stb_o  = (st_q == StReq);
    bus.wb_we_o   = we_q;
    bus.wb_addr_o = addr_q;
    bus.wb_data_o = wdata_q;
  end

endmodule

// File: doc/wb_req_master.md
WB_REQ_MASTER -- requirements
Module: wb_req_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, range 1..255: max cycles in BUS state before abort.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_we  input  4  byte write enables; 0000 = read.
REQ-007 cmd_addr  input  11  word address; bit 10 selects RAM bank downstream.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_rdata  output  32  read data (zero for writes and timeouts).
REQ-012 rsp_err  output  1  transaction aborted by timeout.
REQ-013 wb_cyc_o, wb_stb_o  output  1 each  Wishbone pipelined cycle/strobe to one arbiter port.
REQ-014 wb_we_o  output  4; wb_addr_o  output  11; wb_data_o  output  32  request fields.
REQ-015 wb_stall_i, wb_ack_i  input  1 each; wb_data_i  input  32  arbiter port response.

Function
REQ-016 FSM states IDLE, REQ, WAIT, RESP; one transaction outstanding at most.
REQ-017 cmd_ready = 1 only in IDLE; cmd_valid&&cmd_ready registers we/addr/wdata and moves to REQ next cycle.
REQ-018 REQ: wb_cyc_o=wb_stb_o=1, fields driven from registered command, held stable while wb_stall_i=1.
REQ-019 REQ with wb_stall_i=0: strobe accepted that edge; ack same cycle -> RESP, else -> WAIT.
REQ-020 WAIT: wb_cyc_o=1, wb_stb_o=0; wb_ack_i=1 -> RESP.
REQ-021 On accepted ack, rsp_rdata captures wb_data_i if registered we==0, else 0; rsp_err=0.
REQ-022 Cycle counter clears on REQ entry, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES without ack -> RESP with rsp_err=1, rsp_rdata=0, cyc/stb dropped.
REQ-023 Ack in same cycle as counter reaching limit: ack wins, rsp_err=0.
REQ-024 RESP: rsp_valid=1, cyc/stb=0, rsp fields stable until rsp_valid&&rsp_ready -> IDLE.
REQ-025 Latency: command accepted cycle N -> wb_stb_o high N+1; ack at cycle M -> rsp_valid high M+1; minimum accept-to-response 2 cycles.
REQ-026 wb_ack_i in IDLE or RESP ignored, no state change.
REQ-027 wb_stb_o never asserted without wb_cyc_o; wb_cyc_o deasserts the cycle after ack or timeout.
REQ-028 New command not accepted in the cycle rsp handshake completes (cmd_ready rises next cycle).

Reset
REQ-029 rst=1 at edge -> IDLE; wb_cyc_o=wb_stb_o=0, wb_we_o=0, wb_addr_o=0, wb_data_o=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=0 during reset, 1 first cycle after release, counter 0.
REQ-030 Reset mid-transaction (REQ/WAIT/RESP) aborts immediately; cyc/stb low next cycle; pending response discarded; late ack after reset ignored.

Verification
REQ-031 Write: cmd we=1111 addr=0x000 data=0xA5A5A5A5, stall=0, ack next cycle -> stb 1 cycle, rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-032 Read: addr=0x400, stall held 3 cycles then ack with wb_data_i=0x5A5A5A5A -> stb/addr stable 4 cycles, rsp_rdata=0x5A5A5A5A.
REQ-033 Same-cycle ack: stall=0 and ack=1 on first REQ cycle -> direct to RESP, rsp_valid next cycle.
REQ-034 Timeout: TIMEOUT_CYCLES=4, never ack -> cyc drops after 4 bus cycles, rsp_err=1, rsp_rdata=0; ack on 4th cycle -> rsp_err=0.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held, cmd_ready=0, cmd_valid ignored; cmd_ready=1 cycle after handshake.
REQ-036 rst asserted during WAIT, ack arrives next cycle -> no rsp_valid, outputs at reset values, next command completes normally.
